// File: rtl/nav_data_mod.sv
// Navigation-data modulator downstream of the C/A code generator: chip/epoch/bit timing,
// one-deep word holding register, MSB-first data shifting. Optional macro: UNDERRUN_CNT_EN.
module nav_data_mod #(
  parameter int unsigned CHIPS_PER_EPOCH = 1023,
  parameter int unsigned EPOCHS_PER_BIT  = 20,
  parameter int unsigned WORD_W          = 30
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ena_in,
  input  logic              gc_in,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid_in,
  output logic              word_ready_out,
  output logic              sig_out,
  output logic              epoch_out,
  output logic              bit_strobe_out,
  output logic              underrun_out
`ifdef UNDERRUN_CNT_EN
  ,
  output logic [7:0]        underrun_cnt_out
`endif
);

  localparam int unsigned CW = (CHIPS_PER_EPOCH > 1) ? $clog2(CHIPS_PER_EPOCH) : 1;
  localparam int unsigned EW = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
  localparam int unsigned BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     chip_cnt;
  logic [EW-1:0]     epoch_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [WORD_W-1:0] hold_reg;
  logic [WORD_W-1:0] shift_reg;
  logic              hold_full;

  logic chip_wrap, epoch_wrap, bit_end, last_bit, accept;
  logic load_shift, do_shift, underrun, data_bit;

  assign chip_wrap      = (chip_cnt == CW'(CHIPS_PER_EPOCH - 1));
  assign epoch_wrap     = (epoch_cnt == EW'(EPOCHS_PER_BIT - 1));
  assign bit_end        = ena_in & chip_wrap & epoch_wrap;
  assign last_bit       = (bit_cnt == BW'(WORD_W - 1));
  assign word_ready_out = ~hold_full;
  assign accept         = word_valid_in & ~hold_full;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_shift = 1'b0;
    do_shift   = 1'b0;
    underrun   = 1'b0;
    data_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (bit_end && hold_full) begin
          load_shift = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        data_bit = shift_reg[WORD_W-1];
        if (bit_end) begin
          if (!last_bit) begin
            do_shift = 1'b1;
          end else if (hold_full) begin
            load_shift = 1'b1;
          end else begin
            underrun   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      chip_cnt       <= '0;
      epoch_cnt      <= '0;
      bit_cnt        <= '0;
      hold_reg       <= '0;
      shift_reg      <= '0;
      hold_full      <= 1'b0;
      sig_out        <= 1'b0;
      epoch_out      <= 1'b0;
      bit_strobe_out <= 1'b0;
      underrun_out   <= 1'b0;
    end else begin
      epoch_out      <= ena_in & chip_wrap;
      bit_strobe_out <= bit_end;
      underrun_out   <= underrun;

      if (ena_in) begin
        sig_out  <= gc_in ^ data_bit;
        chip_cnt <= chip_wrap ? '0 : chip_cnt + CW'(1);
        if (chip_wrap) epoch_cnt <= epoch_wrap ? '0 : epoch_cnt + EW'(1);
      end

      if (load_shift) begin
        shift_reg <= hold_reg;
        bit_cnt   <= '0;
      end else if (do_shift) begin
        shift_reg <= shift_reg << 1;
        bit_cnt   <= bit_cnt + BW'(1);
      end

      // A same-edge capture wins over the transfer's clear; the transfer reads the old hold_reg.
      if (accept) begin
        hold_reg  <= word_in;
        hold_full <= 1'b1;
      end else if (load_shift) begin
        hold_full <= 1'b0;
      end
    end
  end

`ifdef UNDERRUN_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in)                                underrun_cnt_out <= '0;
    else if (underrun && underrun_cnt_out != '1) underrun_cnt_out <= underrun_cnt_out + 8'd1;
  end
`endif

endmodule

// File: doc/nav_data_mod.md
Name: nav_data_mod

Overview:
- Downstream stage of the C/A Gold code generator.
- Consumes the generator's registered chip stream `gc_in` on the shared chip strobe `ena_in`.
- Maintains chip, epoch and nav-bit timing, and modulates 50 bps navigation data onto the code (chip XOR data bit).
- Navigation words enter through a valid/ready handshake into a one-deep holding register, and are then shifted out MSB-first.

Parameters:
- CHIPS_PER_EPOCH, 1023, code chips per code epoch (1 ms).
- EPOCHS_PER_BIT, 20, code epochs per navigation bit.
- WORD_W, 30, navigation word width in bits.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-high
- ena_in  input  1  chip strobe, one clk_in cycle per chip; same strobe that advances the code generator
- gc_in  input  1  C/A chip from the code generator
- word_in  input  WORD_W  navigation word, MSB transmitted first
- word_valid_in  input  1  word_in valid
- word_ready_out  output  1  holding register empty; word accepted when valid&ready
- sig_out  output  1  modulated chip = gc_in ^ data_bit
- epoch_out  output  1  one-cycle pulse on the strobe that ends an epoch
- bit_strobe_out  output  1  one-cycle pulse on the strobe that ends a nav bit
- underrun_out  output  1  one-cycle pulse when a word ends with the holding register empty

Behaviour:
- Reset (rst_in=1 on a clk_in edge):
  - chip_cnt=0, epoch_cnt=0, bit_cnt=0.
  - Holding register empty, shift register=0, state IDLE.
  - Outputs: sig_out=0, epoch_out=0, bit_strobe_out=0, underrun_out=0, word_ready_out=1 from the first cycle after reset.
  - Reset mid-word discards both the holding and shift contents.
- Counters advance only on ena_in=1:
  - chip_cnt wraps CHIPS_PER_EPOCH-1 -> 0.
  - epoch_cnt increments on the chip wrap and wraps EPOCHS_PER_BIT-1 -> 0.
  - Define bit_end = ena_in & chip wrap & epoch wrap.
- epoch_out is registered: it is 1 in the cycle after the strobe with chip_cnt=CHIPS_PER_EPOCH-1, otherwise 0. bit_strobe_out is registered the same way from bit_end.
- sig_out is registered and updates only on ena_in=1, to gc_in ^ data_bit; it holds between strobes.
  - data_bit = shift MSB in RUN.
  - data_bit = 0 in IDLE, so the output is the unmodulated code.
- Handshake:
  - word_ready_out = ~hold_full.
  - Acceptance (word_valid_in & word_ready_out) captures word_in and sets hold_full on the next edge.
  - word_valid_in while not ready is ignored; the source must hold the word.
- State IDLE:
  - At bit_end with hold_full=1: move hold -> shift, clear hold_full, bit_cnt=0, go to RUN.
  - Otherwise stay in IDLE.
- State RUN, at bit_end:
  - If bit_cnt<WORD_W-1: shift left by 1, bit_cnt+1.
  - If bit_cnt=WORD_W-1 and hold_full=1: load hold -> shift, clear hold_full, bit_cnt=0, stay RUN. This is a seamless back-to-back word.
  - If bit_cnt=WORD_W-1 and hold_full=0: pulse underrun_out for one cycle, go to IDLE.
- Acceptance and transfer in the same cycle: the transfer uses the old hold contents and the new word is captured. The net result is hold_full=1, and word_ready_out is 0 the next cycle.
- Bit boundaries always align to epoch boundaries. A word accepted mid-bit waits for the next bit_end.
- ena_in=0 for any duration freezes all counters, state and sig_out. Handshake acceptance still works while frozen.

Optional Feature:
- Macro UNDERRUN_CNT_EN.
- When defined:
  - Extra output port underrun_cnt_out, 8 bits.
  - Increments on each underrun_out pulse and saturates at 255.
  - Resets to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Params CHIPS_PER_EPOCH=7, EPOCHS_PER_BIT=2, WORD_W=4, ena_in=1 continuously, no word -> epoch_out every 7 cycles, bit_strobe_out every 14 cycles, sig_out == gc_in delayed one cycle, underrun_out=0.
- Same params, word 4'b1010 accepted before the first bit_end:
  - Following 4 bits (14 chips each) give sig_out = gc_in ^ 1,0,1,0.
  - underrun_out pulses once at the 4th bit_end; IDLE afterwards.
- Words 4'b1100 and then 4'b0011 presented back-to-back with valid held -> 8 contiguous bits 1,1,0,0,0,0,1,1, no underrun. word_ready_out goes 0 after the second acceptance and returns to 1 at the transfer.
- ena_in asserted once every 3 cycles -> counters and sig_out change only on strobes, and epoch_out spacing is 21 cycles.
- rst_in pulsed during bit 2 of word 4'b1111 -> all outputs 0 next cycle, word_ready_out=1, the next strobes output unmodulated gc_in, and counters restart at 0.
- UNDERRUN_CNT_EN defined, 3 single words each followed by starvation -> underrun_cnt_out=3; after forcing 300 underruns, underrun_cnt_out=255.
